// File: rtl/flash_score_store.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flash_score_store: saves/loads a multi-byte score record in NOR flash     |
// | through a go/done byte access stage. Option: FLASH_STORE_VERIFY_EN.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module flash_score_store #(
    parameter logic [7:0] BASE_ADDR  = 8'h00,
    parameter int         NUM_BYTES  = 2,
    parameter int         POLL_LIMIT = 255
) (
    input  logic                   clk_f,
    input  logic                   rst,
    input  logic                   save_req,
    input  logic                   load_req,
    input  logic [8*NUM_BYTES-1:0] score_in,
    output logic [8*NUM_BYTES-1:0] score_out,
    output logic                   busy,
    output logic                   op_done,
    output logic                   error,
    output logic [7:0]             fl_addr,
    output logic [7:0]             fl_wdata,
    output logic                   fl_dir,
    output logic                   fl_go,
    input  logic [7:0]             fl_rdata,
    input  logic                   fl_done
);
    localparam int         W         = 8 * NUM_BYTES;
    localparam logic [3:0] LAST_IDX  = 4'(NUM_BYTES - 1);
    localparam logic [7:0] POLL_MAX  = 8'(POLL_LIMIT);
    localparam logic [7:0] CMD_PROG  = 8'h40;
    localparam logic [7:0] CMD_STAT  = 8'h70;
    localparam logic [7:0] CMD_CLR   = 8'h50;
    localparam logic [7:0] CMD_ARRAY = 8'hFF;

    typedef enum logic [3:0] {
        IDLE, P_SETUP, P_DATA, P_STAT, P_POLL, E_CLR, S_ARRAY,
        L_ARRAY, L_READ,
`ifdef FLASH_STORE_VERIFY_EN
        V_READ,
`endif
        FIN
    } state_t;

    state_t         state, state_n;
    logic           waiting, waiting_n;
    logic [3:0]     idx, idx_n;
    logic [7:0]     poll_cnt, poll_n;
    logic [W-1:0]   record, record_n;
    logic [W-1:0]   shadow, shadow_n;
    logic [W-1:0]   score_n;
    logic           error_n;
    logic           access_done;

    function automatic logic [7:0] byte_of(input logic [W-1:0] v, input logic [3:0] k);
        byte_of = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (k == 4'(i)) byte_of = v[8*i +: 8];
        end
    endfunction

    assign fl_addr = BASE_ADDR + {4'b0000, idx};

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        poll_n    = poll_cnt;
        record_n  = record;
        shadow_n  = shadow;
        score_n   = score_out;
        error_n   = error;
        fl_dir    = 1'b1;
        fl_wdata  = CMD_ARRAY;
        busy      = (state != IDLE) && (state != FIN);
        op_done   = (state == FIN);
        // Every non-idle, non-final state is one access: go once, then wait for done.
        fl_go       = busy && !waiting;
        access_done = waiting && fl_done;
        waiting_n   = busy && (waiting ? !fl_done : 1'b1);

        case (state)
            IDLE: begin
                if (save_req) begin
                    record_n = score_in;
                    error_n  = 1'b0;
                    idx_n    = '0;
                    poll_n   = '0;
                    state_n  = P_SETUP;
                end else if (load_req) begin
                    error_n  = 1'b0;
                    idx_n    = '0;
                    state_n  = L_ARRAY;
                end
            end
            P_SETUP: begin
                fl_dir   = 1'b0;
                fl_wdata = CMD_PROG;
                if (access_done) state_n = P_DATA;
            end
            P_DATA: begin
                fl_dir   = 1'b0;
                fl_wdata = byte_of(record, idx);
                if (access_done) state_n = P_STAT;
            end
            P_STAT: begin
                fl_dir   = 1'b0;
                fl_wdata = CMD_STAT;
                if (access_done) begin
                    poll_n  = '0;
                    state_n = P_POLL;
                end
            end
            P_POLL: begin
                if (access_done) begin
                    if (!fl_rdata[7]) begin
                        if (poll_cnt == POLL_MAX - 8'd1) begin
                            error_n = 1'b1;
                            state_n = E_CLR;
                        end else begin
                            poll_n = poll_cnt + 8'd1;
                        end
                    end else if (fl_rdata[4] || fl_rdata[3]) begin
                        error_n = 1'b1;
                        state_n = E_CLR;
                    end else begin
                        poll_n = '0;
                        if (idx == LAST_IDX) begin
                            idx_n   = '0;
                            state_n = S_ARRAY;
                        end else begin
                            idx_n   = idx + 4'd1;
                            state_n = P_SETUP;
                        end
                    end
                end
            end
            E_CLR: begin
                fl_dir   = 1'b0;
                fl_wdata = CMD_CLR;
                if (access_done) begin
                    idx_n   = '0;
                    state_n = S_ARRAY;
                end
            end
            S_ARRAY: begin
                fl_dir   = 1'b0;
                fl_wdata = CMD_ARRAY;
                if (access_done) begin
`ifdef FLASH_STORE_VERIFY_EN
                    state_n = error ? FIN : V_READ;
`else
                    state_n = FIN;
`endif
                end
            end
`ifdef FLASH_STORE_VERIFY_EN
            V_READ: begin
                if (access_done) begin
                    if (fl_rdata != byte_of(record, idx)) error_n = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_n   = '0;
                        state_n = FIN;
                    end else begin
                        idx_n   = idx + 4'd1;
                    end
                end
            end
`endif
            L_ARRAY: begin
                fl_dir   = 1'b0;
                fl_wdata = CMD_ARRAY;
                if (access_done) state_n = L_READ;
            end
            L_READ: begin
                if (access_done) begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (idx == 4'(i)) shadow_n[8*i +: 8] = fl_rdata;
                    end
                    // Whole record lands in score_out at once, on entry to FIN.
                    if (idx == LAST_IDX) begin
                        score_n = shadow_n;
                        idx_n   = '0;
                        state_n = FIN;
                    end else begin
                        idx_n   = idx + 4'd1;
                    end
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_f or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            waiting   <= 1'b0;
            idx       <= '0;
            poll_cnt  <= '0;
            record    <= '0;
            shadow    <= '0;
            score_out <= '0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            waiting   <= waiting_n;
            idx       <= idx_n;
            poll_cnt  <= poll_n;
            record    <= record_n;
            shadow    <= shadow_n;
            score_out <= score_n;
            error     <= error_n;
        end
    end
endmodule
`default_nettype wire

// File: doc/flash_score_store.md
Name: flash_score_store

Overview:
- Upstream sequencer for the byte-wide parallel flash access stage. Saves or restores a multi-byte scoreboard record in NOR flash.
- Turns one save/load request from the score logic into the Intel-style command sequence: program setup, data write, status poll, read-array, byte reads.
- Each flash access is one handshake (go pulse, done pulse) with the flash access stage. All flash timing lives in that stage.

Parameters:
- BASE_ADDR, 8'h00, flash byte address of record byte 0.
- NUM_BYTES, 2, record length in bytes (1..8). Byte k is at BASE_ADDR+k and holds score bits [8k+7:8k] (LSB first).
- POLL_LIMIT, 255, maximum status reads per programmed byte before timeout (1..255).

Ports:
- clk_f  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- save_req  in  1  1-cycle pulse: program score_in into flash
- load_req  in  1  1-cycle pulse: read record from flash
- score_in  in  8*NUM_BYTES  record to save, sampled on the accepted save_req cycle
- score_out  out  8*NUM_BYTES  last loaded record
- busy  out  1  high from accept until op_done
- op_done  out  1  1-cycle pulse at end of any operation
- error  out  1  sticky fail flag of the last operation
- fl_addr  out  8  byte address to access stage
- fl_wdata  out  8  write byte/command to access stage
- fl_dir  out  1  1 = read, 0 = write
- fl_go  out  1  1-cycle access start pulse
- fl_rdata  in  8  read byte, valid in the fl_done cycle
- fl_done  in  1  1-cycle access-complete pulse

Behaviour:
- Reset values: busy=0, op_done=0, error=0, fl_go=0, fl_dir=1, fl_addr=BASE_ADDR, fl_wdata=8'hFF, score_out=0. State=IDLE, byte index=0, poll count=0.
- Access rule:
  - Each access state asserts fl_go for exactly one cycle, with fl_addr/fl_wdata/fl_dir already valid. These hold stable until fl_done.
  - Only one access is outstanding at a time.
  - fl_done outside a wait state is ignored.
  - fl_done in the same cycle as fl_go is illegal and is not handled.
- IDLE:
  - save_req accepted: latch score_in, busy=1, error=0, index=0, go to P_SETUP.
  - load_req accepted (without save_req): busy=1, error=0, go to L_ARRAY.
  - save_req and load_req in the same cycle: save wins, load is dropped.
  - Requests while busy are dropped.
- Save path, per byte k, at address BASE_ADDR+k:
  - P_SETUP: write 8'h40.
  - P_DATA: write byte k.
  - P_STAT: write 8'h70.
  - P_POLL: read status. bit7=0: poll count+1, re-read. bit7=1: check error bits.
  - Error bits: bit4 or bit3 set sets error and goes to E_CLR. Otherwise index+1. If index==NUM_BYTES-1 go to S_ARRAY, else back to P_SETUP. Poll count clears per byte.
  - Timeout: POLL_LIMIT status reads with bit7=0 sets error and goes to E_CLR.
  - E_CLR: write 8'h50, then S_ARRAY.
  - S_ARRAY: write 8'hFF, then FIN.
- Load path:
  - L_ARRAY: write 8'hFF.
  - L_READ: read BASE_ADDR+k for k=0..NUM_BYTES-1. Store fl_rdata into a shadow register.
  - After the last byte, copy shadow to score_out in a single cycle, then FIN. score_out never shows a partial record.
- FIN: op_done=1 for one cycle, busy=0 in the same cycle, then IDLE. error holds until the next accepted request.
- Address arithmetic is 8-bit and wraps modulo 256 (BASE_ADDR=8'hFF, k=1 gives 8'h00).
- Reset mid-operation:
  - Immediate return to IDLE with reset values; score_out resets to 0.
  - A pending fl_done after reset is ignored.
  - No recovery command is issued.
- Minimum save latency with ideal 1-cycle access: 4 accesses per byte + 1 + FIN. Each access costs go + done cycles.

Optional Feature:
- Macro FLASH_STORE_VERIFY_EN.
- Defined:
  - After S_ARRAY on an error-free save, state V_READ reads back all NUM_BYTES bytes and compares each with the latched record.
  - Any mismatch sets error. All bytes are still read.
  - score_out is not modified.
- Undefined: V_READ does not exist. Save ends at S_ARRAY then FIN.

Test Plan:
- Save 16'hA55A, ideal flash model (status 8'h80 on first poll) -> fl_wdata sequence 40,5A,70,(read),40,A5,70,(read),FF; addresses 00,00,00,00,01,01,01,01,00; one op_done; error=0.
- Load with flash holding 00:8'h34, 01:8'h12 -> write FF then reads at 00,01; score_out=16'h1234 updated only in the FIN cycle; busy falls with op_done.
- Status stuck at 8'h00, POLL_LIMIT=4 -> exactly 4 status reads, then 50 and FF writes; error=1; op_done once.
- Status 8'h90 on byte 0 -> no byte-1 accesses, 50 then FF, error=1; next accepted load clears error to 0.
- save_req and load_req in the same cycle, then load_req again while busy -> save only runs, no load performed; rst asserted mid P_POLL -> busy=0, fl_go=0 immediately, stale fl_done ignored.
- With FLASH_STORE_VERIFY_EN, model corrupts byte 1 to 8'h00 -> readback at 00,01 after FF; error=1.
